// File: rtl/framebuffer_ctrl.sv
// Double-buffered framebuffer controller sharing one single-port memory between drawing writes
// and VGA scanout reads. Optional macro FB_DROP_CNT_EN adds the drop_cnt output.
module framebuffer_ctrl #(
    parameter int X_MIN  = 80,
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 240
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic [7:0]  draw_color,
    input  logic        draw_done,
    output logic        wr_en,
    output logic        buffer_using,
    input  logic        pix_en,
    input  logic [9:0]  vga_x,
    input  logic [9:0]  vga_y,
    input  logic        vs,
    output logic [7:0]  vga_color,
`ifdef FB_DROP_CNT_EN
    output logic [15:0] drop_cnt,
`endif
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    localparam logic [10:0] X_LO     = 11'(X_MIN);
    localparam logic [10:0] X_HI     = 11'(X_MIN + WIDTH - 1);
    localparam logic [10:0] Y_HI     = 11'(HEIGHT - 1);
    localparam logic [16:0] BUF_SIZE = 17'(WIDTH * HEIGHT);

    typedef enum logic {IDLE, PENDING} swap_state_t;

    swap_state_t state, state_next;
    logic        buffer_next;
    logic [1:0]  vs_hist;
    logic        vs_fall;
    logic        swap_pending;
    logic        rd_valid;
    logic        rd_in_region;
    logic [16:0] addr_q;
    logic        draw_in_region;
    logic        scan_in_region;
    logic        scan_rd;

    function automatic logic in_region(input logic [9:0] x, input logic [9:0] y);
        return ({1'b0, x} >= X_LO) && ({1'b0, x} <= X_HI) && ({1'b0, y} <= Y_HI);
    endfunction

    function automatic logic [16:0] pixel_addr(input logic b, input logic [9:0] x,
                                               input logic [9:0] y);
        logic [16:0] base;
        base = b ? BUF_SIZE : 17'd0;
        return base + 17'(y) * 17'(WIDTH) + (17'(x) - 17'(X_MIN));
    endfunction

    assign vs_fall        = (vs_hist == 2'b10);
    assign swap_pending   = (state == PENDING);
    assign draw_in_region = in_region(draw_x, draw_y);
    assign scan_in_region = in_region(vga_x, vga_y);

    // Scanout owns the memory port whenever pix_en is high; a pending swap freezes drawing.
    assign scan_rd   = !Reset && pix_en && scan_in_region;
    assign wr_en     = !Reset && !pix_en && !swap_pending;
    assign mem_we    = wr_en && draw_in_region;
    assign mem_wdata = draw_color;

    always_comb begin
        mem_addr = addr_q;
        if (scan_rd)
            mem_addr = pixel_addr(buffer_using, vga_x, vga_y);
        else if (mem_we)
            mem_addr = pixel_addr(!buffer_using, draw_x, draw_y);
    end

    // A draw_done coinciding with a vs falling edge swaps immediately instead of waiting a frame.
    always_comb begin
        state_next  = state;
        buffer_next = buffer_using;
        case (state)
            IDLE: begin
                if (draw_done) begin
                    if (vs_fall)
                        buffer_next = !buffer_using;
                    else
                        state_next = PENDING;
                end
            end
            PENDING: begin
                if (vs_fall) begin
                    buffer_next = !buffer_using;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            buffer_using <= 1'b0;
            vs_hist      <= 2'b11;
            rd_valid     <= 1'b0;
            rd_in_region <= 1'b0;
            vga_color    <= 8'h00;
            addr_q       <= 17'd0;
        end else begin
            state        <= state_next;
            buffer_using <= buffer_next;
            vs_hist      <= {vs_hist[0], vs};
            rd_valid     <= pix_en;
            rd_in_region <= scan_in_region;
            addr_q       <= mem_addr;
            // Off-region scanout pixels still produce a result, forced to black.
            if (rd_valid)
                vga_color <= rd_in_region ? mem_rdata : 8'h00;
        end
    end

`ifdef FB_DROP_CNT_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            drop_cnt <= 16'h0000;
        else if (wr_en && !draw_in_region && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Self-checking bench for framebuffer_ctrl: directed vector table, corner-case sequences,
// and randomized traffic checked against a behavioural model.
module tb_framebuffer_ctrl;

    localparam int X_MIN  = 80;
    localparam int WIDTH  = 160;
    localparam int HEIGHT = 240;

    logic        Clk;
    logic        Reset;
    logic [9:0]  draw_x, draw_y;
    logic [7:0]  draw_color;
    logic        draw_done;
    logic        wr_en;
    logic        buffer_using;
    logic        pix_en;
    logic [9:0]  vga_x, vga_y;
    logic        vs;
    logic [7:0]  vga_color;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
`ifdef FB_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_checks;
    int n_fail;

    framebuffer_ctrl #(.X_MIN(X_MIN), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .draw_color   (draw_color),
        .draw_done    (draw_done),
        .wr_en        (wr_en),
        .buffer_using (buffer_using),
        .pix_en       (pix_en),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vs           (vs),
        .vga_color    (vga_color),
`ifdef FB_DROP_CNT_EN
        .drop_cnt     (drop_cnt),
`endif
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        pix;
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [7:0]  col;
        logic [9:0]  vx;
        logic [9:0]  vy;
        logic        exp_wr;
        logic        exp_we;
        logic [16:0] exp_addr;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    function automatic vec_t mkvec(logic pix, int dx, int dy, int col, int vx, int vy,
                                   logic ew, logic ewe, int ea);
        vec_t v;
        v.pix      = pix;
        v.dx       = 10'(dx);
        v.dy       = 10'(dy);
        v.col      = 8'(col);
        v.vx       = 10'(vx);
        v.vy       = 10'(vy);
        v.exp_wr   = ew;
        v.exp_we   = ewe;
        v.exp_addr = 17'(ea);
        return v;
    endfunction

    function automatic bit m_inreg(int x, int y);
        return (x >= X_MIN) && (x < X_MIN + WIDTH) && (y >= 0) && (y < HEIGHT);
    endfunction

    function automatic int m_addr(bit b, int x, int y);
        return (b ? WIDTH * HEIGHT : 0) + y * WIDTH + (x - X_MIN);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic pix, input logic [9:0] dx, input logic [9:0] dy,
                                 input logic [7:0] col, input logic [9:0] vx, input logic [9:0] vy,
                                 input logic v, input logic dd, input logic [7:0] rd);
        pix_en     = pix;
        draw_x     = dx;
        draw_y     = dy;
        draw_color = col;
        vga_x      = vx;
        vga_y      = vy;
        vs         = v;
        draw_done  = dd;
        mem_rdata  = rd;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        applyStimulus(1'b0, 10'd0, 10'd0, 8'h00, 10'd0, 10'd0, 1'b1, 1'b0, 8'h00);
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // model state for the randomized phase
    bit       m_front, m_pending, m_prev_rd, m_prev_in;
    bit       m_vs_q[$];
    int       m_held, m_drop, exp_drop;
    logic [7:0] m_vga;
    bit       r_rst, r_pix, r_vs, r_dd, r_fall, d_in, s_in, e_wr, e_we;
    int       r_dx, r_dy, r_vx, r_vy, r_col, r_rd, e_addr;
    bit       swapped;
    int       swap_k;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = mkvec(1'b0,  80,   0, 8'h3F,   0,   0, 1'b1, 1'b1, 38400);
        vecs[1]  = mkvec(1'b0, 239, 239, 8'h07,   0,   0, 1'b1, 1'b1, 76799);
        vecs[2]  = mkvec(1'b0,  10,  10, 8'h11,   0,   0, 1'b1, 1'b0, 76799);
        vecs[3]  = mkvec(1'b0, 240,   0, 8'h22,   0,   0, 1'b1, 1'b0, 76799);
        vecs[4]  = mkvec(1'b0,  80, 240, 8'h33,   0,   0, 1'b1, 1'b0, 76799);
        vecs[5]  = mkvec(1'b0,  79,   5, 8'h44,   0,   0, 1'b1, 1'b0, 76799);
        vecs[6]  = mkvec(1'b0, 100,   3, 8'hAA,   0,   0, 1'b1, 1'b1, 38900);
        vecs[7]  = mkvec(1'b1,  81,   0, 8'h55,  80,   0, 1'b0, 1'b0, 0);
        vecs[8]  = mkvec(1'b1,  81,   0, 8'h55, 239, 239, 1'b0, 1'b0, 38399);
        vecs[9]  = mkvec(1'b1,  81,   0, 8'h55,   5,   5, 1'b0, 1'b0, 38399);
        vecs[10] = mkvec(1'b1,  81,   0, 8'h55, 150, 100, 1'b0, 1'b0, 16070);
        vecs[11] = mkvec(1'b0, 159, 119, 8'h5A,   0,   0, 1'b1, 1'b1, 57519);

        // reset state
        Reset = 1'b1;
        applyStimulus(1'b0, 10'd80, 10'd0, 8'h3F, 10'd0, 10'd0, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        tick();
        checkOutput("rst_buffer_using", 32'(buffer_using), 32'd0);
        checkOutput("rst_vga_color", 32'(vga_color), 32'd0);
`ifdef FB_DROP_CNT_EN
        checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        Reset = 1'b0;

        // directed vector table
        exp_drop = 0;
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].pix, vecs[i].dx, vecs[i].dy, vecs[i].col,
                          vecs[i].vx, vecs[i].vy, 1'b1, 1'b0, 8'h00);
            #1;
            checkOutput($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].exp_wr));
            checkOutput($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
            checkOutput($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_addr));
            if (vecs[i].exp_we)
                checkOutput($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].col));
            if (vecs[i].exp_wr && !vecs[i].exp_we)
                exp_drop++;
            tick();
`ifdef FB_DROP_CNT_EN
            checkOutput($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(exp_drop));
`endif
        end

        // scanout latency, off-region black, and hold
        doReset();
        applyStimulus(1'b1, 10'd10, 10'd10, 8'h00, 10'd80, 10'd0, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("scan_wr_en", 32'(wr_en), 32'd0);
        checkOutput("scan_mem_we", 32'(mem_we), 32'd0);
        checkOutput("scan_mem_addr", 32'(mem_addr), 32'd0);
        tick();
        applyStimulus(1'b0, 10'd10, 10'd10, 8'h00, 10'd0, 10'd0, 1'b1, 1'b0, 8'h2C);
        #1;
        checkOutput("scan_vga_early", 32'(vga_color), 32'h00);
        tick();
        applyStimulus(1'b0, 10'd10, 10'd10, 8'h00, 10'd0, 10'd0, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("scan_vga_2c", 32'(vga_color), 32'h2C);
        tick();
        applyStimulus(1'b1, 10'd10, 10'd10, 8'h00, 10'd5, 10'd5, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("scan_skip_we", 32'(mem_we), 32'd0);
        checkOutput("scan_skip_hold_addr", 32'(mem_addr), 32'd0);
        tick();
        applyStimulus(1'b0, 10'd10, 10'd10, 8'h00, 10'd0, 10'd0, 1'b1, 1'b0, 8'h55);
        tick();
        applyStimulus(1'b1, 10'd10, 10'd10, 8'h00, 10'd81, 10'd1, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("scan_offregion_black", 32'(vga_color), 32'h00);
        checkOutput("scan_addr_161", 32'(mem_addr), 32'd161);
        tick();
        applyStimulus(1'b0, 10'd10, 10'd10, 8'h00, 10'd0, 10'd0, 1'b1, 1'b0, 8'h99);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 10'd10, 10'd10, 8'h00, 10'd0, 10'd0, 1'b1, 1'b0, 8'(k + 1));
            #1;
            checkOutput($sformatf("scan_vga_hold%0d", k), 32'(vga_color), 32'h99);
            tick();
        end

        // buffer swap waits for a vs falling edge
        doReset();
        applyStimulus(1'b0, 10'd80, 10'd0, 8'h3F, 10'd0, 10'd0, 1'b1, 1'b1, 8'h00);
        #1;
        checkOutput("swap_done_cycle_wr_en", 32'(wr_en), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 10'd80, 10'd0, 8'h3F, 10'd0, 10'd0, 1'b1, 1'b0, 8'h00);
            #1;
            checkOutput($sformatf("swap_pending_wr_en%0d", k), 32'(wr_en), 32'd0);
            checkOutput($sformatf("swap_pending_buf%0d", k), 32'(buffer_using), 32'd0);
            tick();
        end
        swapped = 1'b0;
        swap_k  = -1;
        for (int k = 0; k < 8 && !swapped; k++) begin
            applyStimulus(1'b0, 10'd80, 10'd0, 8'h3F, 10'd0, 10'd0, 1'b0, 1'b0, 8'h00);
            #1;
            if (buffer_using === 1'b1) begin
                swapped = 1'b1;
                swap_k  = k;
            end else begin
                checkOutput($sformatf("swap_wait_wr_en%0d", k), 32'(wr_en), 32'd0);
                tick();
            end
        end
        checkOutput("swap_happened", 32'(swapped), 32'd1);
        checkOutput("swap_latency", 32'(swap_k), 32'd2);
        checkOutput("swap_new_wr_en", 32'(wr_en), 32'd1);
        checkOutput("swap_new_mem_we", 32'(mem_we), 32'd1);
        checkOutput("swap_new_mem_addr", 32'(mem_addr), 32'd0);
        tick();

        // reset while a swap is pending
        applyStimulus(1'b0, 10'd80, 10'd0, 8'h3F, 10'd0, 10'd0, 1'b1, 1'b0, 8'h00);
        tick();
        tick();
        applyStimulus(1'b0, 10'd80, 10'd0, 8'h3F, 10'd0, 10'd0, 1'b1, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b0, 10'd80, 10'd0, 8'h3F, 10'd0, 10'd0, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("rstpend_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rstpend_buf_before", 32'(buffer_using), 32'd1);
        Reset = 1'b1;
        #1;
        checkOutput("rstpend_rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rstpend_rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        checkOutput("rstpend_buf_after", 32'(buffer_using), 32'd0);
        checkOutput("rstpend_rst_wr_en2", 32'(wr_en), 32'd0);
        tick();
        Reset = 1'b0;
        #1;
        checkOutput("rstpend_first_wr_en", 32'(wr_en), 32'd1);
        checkOutput("rstpend_first_addr", 32'(mem_addr), 32'd38400);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 10'd80, 10'd0, 8'h3F, 10'd0, 10'd0, 1'b0, 1'b0, 8'h00);
            #1;
            checkOutput($sformatf("rstpend_noswap_buf%0d", k), 32'(buffer_using), 32'd0);
            checkOutput($sformatf("rstpend_noswap_wr%0d", k), 32'(wr_en), 32'd1);
            tick();
        end

        // randomized traffic against the behavioural model
        doReset();
        m_front = 0; m_pending = 0; m_prev_rd = 0; m_prev_in = 0;
        m_vga = 8'h00; m_held = 0; m_drop = 0;
        m_vs_q.delete();
        m_vs_q.push_back(1'b1);
        m_vs_q.push_back(1'b1);
        r_vs = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_pix = ($urandom_range(0, 1) == 1);
            r_dd  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 11) == 0) r_vs = !r_vs;
            r_dx  = $urandom_range(60, 260);
            r_dy  = $urandom_range(0, 260);
            r_vx  = $urandom_range(60, 260);
            r_vy  = $urandom_range(0, 260);
            r_col = $urandom_range(0, 255);
            r_rd  = $urandom_range(0, 255);
            Reset = r_rst;
            applyStimulus(r_pix, 10'(r_dx), 10'(r_dy), 8'(r_col), 10'(r_vx), 10'(r_vy),
                          r_vs, r_dd, 8'(r_rd));
            #1;
            d_in = m_inreg(r_dx, r_dy);
            s_in = m_inreg(r_vx, r_vy);
            e_wr = !r_rst && !r_pix && !m_pending;
            e_we = e_wr && d_in;
            if (!r_rst && r_pix && s_in)
                e_addr = m_addr(m_front, r_vx, r_vy);
            else if (e_we)
                e_addr = m_addr(!m_front, r_dx, r_dy);
            else
                e_addr = m_held;
            checkOutput("rnd_wr_en", 32'(wr_en), 32'(e_wr));
            checkOutput("rnd_mem_we", 32'(mem_we), 32'(e_we));
            checkOutput("rnd_mem_addr", 32'(mem_addr), 32'(e_addr));
            checkOutput("rnd_vga_color", 32'(vga_color), 32'(m_vga));
            checkOutput("rnd_buffer_using", 32'(buffer_using), 32'(m_front));
            if (e_we)
                checkOutput("rnd_mem_wdata", 32'(mem_wdata), 32'(r_col));
`ifdef FB_DROP_CNT_EN
            checkOutput("rnd_drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
            if (r_rst) begin
                m_front = 0; m_pending = 0; m_prev_rd = 0; m_prev_in = 0;
                m_vga = 8'h00; m_held = 0; m_drop = 0;
                m_vs_q.delete();
                m_vs_q.push_back(1'b1);
                m_vs_q.push_back(1'b1);
            end else begin
                r_fall = (m_vs_q[0] == 1'b1) && (m_vs_q[1] == 1'b0);
                if (!m_pending && r_dd) begin
                    if (r_fall) m_front = !m_front;
                    else        m_pending = 1'b1;
                end else if (m_pending && r_fall) begin
                    m_front   = !m_front;
                    m_pending = 1'b0;
                end
                if (m_prev_rd)
                    m_vga = m_prev_in ? 8'(r_rd) : 8'h00;
                m_prev_rd = r_pix;
                m_prev_in = s_in;
                m_held    = e_addr;
                if (e_wr && !d_in && m_drop < 65535)
                    m_drop++;
                m_vs_q.push_back(r_vs);
                void'(m_vs_q.pop_front());
            end
            tick();
        end
        Reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/framebuffer_ctrl.md
FRAMEBUFFER_CTRL -- requirements
Module: framebuffer_ctrl

Interface
REQ-001 The block SHALL have parameter X_MIN, default 80, first drawable column.
REQ-002 The block SHALL have parameter WIDTH, default 160, drawable columns.
REQ-003 The block SHALL have parameter HEIGHT, default 240, drawable rows (row 0 is the first).
REQ-004 The block SHALL have port Clk  input  1  system clock.
REQ-005 The block SHALL have port Reset  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port draw_x, draw_y  input  10 each  pixel coordinate presented by the drawing engine.
REQ-007 The block SHALL have port draw_color  input  8  pixel color presented by the drawing engine.
REQ-008 The block SHALL have port draw_done  input  1  one-cycle pulse: back-buffer frame complete.
REQ-009 The block SHALL have port wr_en  output  1  grant: the presented pixel is consumed at this clock edge.
REQ-010 The block SHALL have port buffer_using  output  1  index of the front (displayed) buffer; drawing targets !buffer_using.
REQ-011 The block SHALL have port pix_en  input  1  scanout pixel strobe.
REQ-012 The block SHALL have port vga_x, vga_y  input  10 each  scanout coordinate.
REQ-013 The block SHALL have port vs  input  1  active-low vertical sync.
REQ-014 The block SHALL have port vga_color  output  8  registered scanout color.
REQ-015 The block SHALL have ports mem_addr (output, 17), mem_wdata (output, 8), mem_we (output, 1) and mem_rdata (input, 8): a single-port memory with 1-cycle read latency.

Function
REQ-016 in_region SHALL mean x in [X_MIN, X_MIN+WIDTH-1] and y in [0, HEIGHT-1].
REQ-017 The address SHALL be buf*WIDTH*HEIGHT + y*WIDTH + (x-X_MIN), computed in 17 bits; with the default parameters buffer 0 spans 0..38399 and buffer 1 spans 38400..76799.
REQ-018 Port arbitration: in a pix_en cycle the block SHALL perform a scanout read and hold wr_en=0; scanout always wins.
REQ-019 In a cycle with pix_en=0, swap_pending=0 and Reset=0, the block SHALL assert wr_en=1 combinationally.
REQ-020 In a wr_en cycle with the draw coordinate in_region, the block SHALL drive mem_we=1, mem_addr=write address into buffer !buffer_using, and mem_wdata=draw_color, all combinational in the same cycle.
REQ-021 In a wr_en cycle with the draw coordinate not in_region, the block SHALL still assert wr_en and consume the pixel, and SHALL drive mem_we=0 (write discarded).
REQ-022 In a scanout cycle N, the block SHALL drive mem_addr=read address into buffer buffer_using and mem_we=0; mem_rdata is valid in cycle N+1; vga_color SHALL be registered at the end of N+1 (visible in N+2).
REQ-023 A scanout coordinate that is not in_region SHALL skip the memory access; a delayed in_region flag SHALL force vga_color=0 with the same 2-cycle latency.
REQ-024 vga_color SHALL hold its value between scanout results.
REQ-025 In a cycle with neither a read nor a write, the block SHALL drive mem_we=0 and hold mem_addr.
REQ-026 Swap FSM state IDLE: on draw_done the block SHALL go to PENDING (swap_pending=1, wr_en forced 0).
REQ-027 Swap FSM state PENDING: on a registered falling edge of vs the block SHALL toggle buffer_using and return to IDLE; writes then resume into the new back buffer.
REQ-028 If draw_done arrives in IDLE in the same cycle as a vs falling edge, the block SHALL swap in that cycle and remain IDLE.
REQ-029 A draw_done arriving while PENDING SHALL be ignored.
REQ-030 A vs falling edge arriving in IDLE SHALL have no effect.
REQ-031 Edge detection on vs SHALL use a 2-flop history; a falling edge is history==2'b10.

Reset
REQ-032 On Reset the block SHALL set buffer_using=0, FSM=IDLE, vga_color=0, clear the read-pipeline valid/in_region flags and set the vs history to 2'b11.
REQ-033 During Reset the block SHALL drive wr_en=0 and mem_we=0.
REQ-034 Reset SHALL take priority over every event, including a pending swap and in-flight reads.

Configuration
REQ-035 With macro FB_DROP_CNT_EN defined, the block SHALL add output drop_cnt [15:0]: incremented on each discarded wr_en cycle (REQ-021), saturating at 16'hFFFF, and cleared by Reset.
REQ-036 Without FB_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Bench SHALL check: after reset, pix_en=0, draw (80,0) color 3F -> wr_en=1, mem_we=1, mem_addr=38400, mem_wdata=3F.
REQ-038 Bench SHALL check: draw (239,239) color 07 with buffer_using=0 -> mem_addr=76799, mem_we=1.
REQ-039 Bench SHALL check: draw (10,10) -> wr_en=1, mem_we=0; with FB_DROP_CNT_EN, drop_cnt 0->1.
REQ-040 Bench SHALL check: pix_en=1, vga (80,0), mem_rdata=2C in the next cycle -> wr_en=0 that cycle, mem_addr=0, vga_color=2C two cycles later; vga (5,5) -> vga_color=00 two cycles later.
REQ-041 Bench SHALL check: draw_done pulse -> wr_en=0 until vs falls; then buffer_using 0->1 and a draw (80,0) writes mem_addr=0.
REQ-042 Bench SHALL check: Reset asserted while PENDING with buffer_using=1 -> buffer_using=0, wr_en=0 during reset, and wr_en=1 in the first pix_en=0 cycle after reset with no swap on the next vs edge.
